// File: rtl/dcache_mem1_resp.sv
// Mem1 data-cache responder: data array plus 2-entry store buffer with bit-level load forwarding.
// Latency: load data 1 cycle after request; stores never stall (a full buffer drains while it accepts).
module dcache_mem1_resp #(
  parameter int CACHE_WIDTHE  = 5,
  parameter int CACHE_DEEPTHE = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ReqVld,
  input  logic                           WrEn,
  input  logic [CACHE_DEEPTHE-1:0]       Addr,
  input  logic [(2**CACHE_WIDTHE)-1:0]   WrMask,
  input  logic [(2**CACHE_WIDTHE)-1:0]   WrData,
  output logic [(2**CACHE_WIDTHE)-1:0]   MemRdData,
  output logic                           RdVld,
  output logic [1:0]                     SbCnt,
  output logic                           SbEmpty
);

  localparam int W     = 2**CACHE_WIDTHE;
  localparam int DEPTH = 2**CACHE_DEEPTHE;

  typedef struct packed {
    logic [CACHE_DEEPTHE-1:0] addr;
    logic [W-1:0]             mask;
    logic [W-1:0]             data;
  } sb_entry_t;

  logic [W-1:0] mem [DEPTH];

  sb_entry_t    sb_q [2];
  sb_entry_t    sb_d [2];
  logic [1:0]   sb_cnt_q, sb_cnt_d;
  logic         sb_empty_q, sb_empty_d;
  logic         rd_vld_q, rd_vld_d;
  logic [W-1:0] rd_data_q, rd_data_d;

  logic         ld_req;
  logic         st_req;
  logic         drain;
  logic [1:0]   slot;
  logic [1:0]   sb_vld;
  logic [W-1:0] rd_merge;

  always_comb begin
    ld_req = ReqVld & ~WrEn;
    st_req = ReqVld & WrEn;
    // Drain on idle cycles; a store drains the head only when it would otherwise overflow,
    // which lets two stores accumulate for forwarding and fence timing.
    drain  = (sb_cnt_q != 2'd0) & ~ld_req & (~st_req | (sb_cnt_q == 2'd2));
    sb_vld = {sb_cnt_q == 2'd2, sb_cnt_q != 2'd0};
    slot   = sb_cnt_q - {1'b0, drain};
  end

  always_comb begin
    sb_d[0] = sb_q[0];
    sb_d[1] = sb_q[1];
    if (drain) begin
      sb_d[0] = sb_q[1];
    end
    if (st_req) begin
      sb_d[slot[0]] = '{addr: Addr, mask: WrMask, data: WrData};
    end
    sb_cnt_d   = sb_cnt_q - {1'b0, drain} + {1'b0, st_req};
    sb_empty_d = (sb_cnt_d == 2'd0);
  end

  // Oldest entry merged first so the younger store owns overlapping bits.
  always_comb begin
    rd_merge = mem[Addr];
    for (int i = 0; i < 2; i++) begin
      if (sb_vld[i] && (sb_q[i].addr == Addr)) begin
        rd_merge = (rd_merge & ~sb_q[i].mask) | (sb_q[i].data & sb_q[i].mask);
      end
    end
    rd_vld_d  = ld_req;
    rd_data_d = ld_req ? rd_merge : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q[0]    <= '0;
      sb_q[1]    <= '0;
      sb_cnt_q   <= 2'd0;
      sb_empty_q <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      sb_q[0]    <= sb_d[0];
      sb_q[1]    <= sb_d[1];
      sb_cnt_q   <= sb_cnt_d;
      sb_empty_q <= sb_empty_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array is not reset; pending stores are discarded by reset rather than written.
  always_ff @(posedge clk) begin
    if (drain && !rst) begin
      mem[sb_q[0].addr] <= (sb_q[0].data & sb_q[0].mask) | (mem[sb_q[0].addr] & ~sb_q[0].mask);
    end
  end

  assign MemRdData = rd_data_q;
  assign RdVld     = rd_vld_q;
  assign SbCnt     = sb_cnt_q;
  assign SbEmpty   = sb_empty_q;

endmodule
